fgp_rx_parser: RTL and testbench
================================

FGP_RX_PARSER -- requirements
Module: fgp_rx_parser

Interface
REQ-001 Parameter OFFSET_BYTES, default 2: number of big-endian offset bytes in the header, legal range 1..4.
REQ-002 Parameter PAD_BYTES, default 125: padding bytes after the offset; the header is always 128 bytes at defaults.
REQ-003 Parameter DATA_BYTES, default 768: payload bytes per packet, legal range 1..1023.
REQ-004 Parameter CHANNELS, default 2: number of legal channel indices, legal range 1..256.
REQ-005 Parameter COLOR_SHIFT, default 9: left shift applied to offset to form setoff_val.
REQ-006 clk  in  1  sole clock; all logic is on posedge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 inclk  in  1  byte strobe; in is valid only when inclk=1.
REQ-009 in  in  8  received byte (BYTE_LEN).
REQ-010 in_done  in  1  end-of-frame pulse from the lower layer; may coincide with inclk.
REQ-011 setoff_req  out  1  one-cycle pulse; the offset is complete.
REQ-012 setoff_chan  out  8  channel index; valid with setoff_req and held until the next header.
REQ-013 setoff_val  out  8*OFFSET_BYTES+COLOR_SHIFT  {offset, COLOR_SHIFT zeros}; valid with setoff_req.
REQ-014 outclk  out  1  payload byte strobe.
REQ-015 out  out  8  payload byte; equals in, combinational, valid with outclk.
REQ-016 done  out  1  one-cycle pulse on the last payload byte.
REQ-017 err  out  1  one-cycle pulse on a detected frame error.
REQ-018 err_code  out  2  error code: 1 = bad channel, 2 = short frame; held until the next err.

Function
REQ-019 Wire format SHALL be [chan (1) | offset (OFFSET_BYTES, MSB first) | pad (PAD_BYTES) | data (DATA_BYTES) | trailing bytes ignored].
REQ-020 The FSM SHALL have the states CHAN, OFFSET, PAD, DATA, TAIL, DROP, with a 10-bit byte counter that clears on every state change.
REQ-021 CHAN SHALL move to OFFSET on inclk, latching in as setoff_chan.
REQ-022 OFFSET SHALL shift in bytes MSB-first and move to PAD on byte OFFSET_BYTES-1.
REQ-023 setoff_req SHALL be combinational with that last offset byte; setoff_val SHALL include that byte through a combinational bypass.
REQ-024 PAD SHALL discard bytes and move to DATA after byte PAD_BYTES-1; if PAD_BYTES=0, OFFSET SHALL go directly to DATA.
REQ-025 DATA SHALL assert outclk=inclk; done SHALL equal inclk AND count=DATA_BYTES-1; the FSM SHALL then move to TAIL.
REQ-026 TAIL SHALL ignore bytes; in_done SHALL return the FSM to CHAN.
REQ-027 DROP SHALL suppress setoff_req, outclk and done; in_done SHALL return the FSM to CHAN.
REQ-028 In-state behaviour with in_done: in every state, when inclk and in_done coincide, the byte SHALL be processed first; the next state SHALL then be CHAN.
REQ-029 Single-byte frame: in_done in the same cycle as the channel byte SHALL return the FSM to CHAN.
REQ-030 in_done while in CHAN with no bytes received SHALL be ignored, with no err.
REQ-031 Outputs SHALL be combinational from registered state and current inputs; latency is 0 cycles.

Reset
REQ-032 rst SHALL set state=CHAN, counter=0, offset shift register=0, setoff_chan=0 and err_code=0.
REQ-033 All pulses SHALL be 0 during reset, and any inclk in the reset cycle SHALL be ignored.
REQ-034 rst mid-frame SHALL abandon the frame; the next byte SHALL be parsed as a channel byte.

Configuration
REQ-035 With FGP_RX_ERR_EN defined: chan>=CHANNELS SHALL pulse err with code 1 and enter DROP in place of OFFSET; in_done in OFFSET, PAD or DATA before done SHALL pulse err with code 2.
REQ-036 With FGP_RX_ERR_EN undefined: err=0 and err_code=0 always; the channel SHALL NOT be checked; a short frame SHALL silently return the FSM to CHAN.

Verification
REQ-037 Defaults, frame chan=1, offset 0x0102, 125 pad, 768 data, 4 trailing bytes, in_done -> setoff_req once with setoff_val=0x020400, 768 outclk, done on byte 896, no err.
REQ-038 Back-to-back frames with in_done on the last trailing byte and the next chan byte in the following cycle -> both frames parsed, 2 done pulses.
REQ-039 ERR_EN defined, chan=5 -> err with code 1 in the chan cycle, zero outclk, recovery on the next frame.
REQ-040 ERR_EN defined, in_done after 300 data bytes -> err with code 2, no done, state CHAN.
REQ-041 rst after 50 data bytes, then a full frame -> outclk count of exactly 768 for the new frame.
REQ-042 OFFSET_BYTES=1, PAD_BYTES=0, DATA_BYTES=3, frame bytes 00 07 AA BB CC -> setoff_val=0x0E00, out AA/BB/CC, done on CC.

Source files
------------

// File: rtl/fgp_rx_parser_if.sv
// ----------------------------------------------------------------------------
// fgp_rx_parser_if
// Byte-stream bus between a lower-layer receiver, the frame parser and its
// consumers.
//
// Handshake semantics: there is no back-pressure. A byte on `in` is valid
// only in a cycle where `inclk` is 1. `in_done` marks the end of the frame
// and may share a cycle with the last byte. Every output pulse
// (setoff_req, outclk, done, err) is valid for exactly the cycle in which it
// is 1. The values that go with a pulse (setoff_val, setoff_chan, out,
// err_code) are valid in that same cycle.
//
// Signals:
//   inclk       byte strobe                      (receiver -> parser)
//   in[7:0]     received byte                    (receiver -> parser)
//   in_done     end-of-frame pulse               (receiver -> parser)
//   setoff_req  offset-complete pulse            (parser -> consumer)
//   setoff_chan channel index of current header  (parser -> consumer)
//   setoff_val  {offset, COLOR_SHIFT zeros}      (parser -> consumer)
//   outclk      payload byte strobe              (parser -> consumer)
//   out[7:0]    payload byte                     (parser -> consumer)
//   done        last-payload-byte pulse          (parser -> consumer)
//   err         frame error pulse                (parser -> consumer)
//   err_code    1 = bad channel, 2 = short frame (parser -> consumer)
// Modports: master = receiver/consumer side, slave = parser side.
// ----------------------------------------------------------------------------
interface fgp_rx_parser_if #(
  parameter int OFFSET_BYTES = 2,
  parameter int COLOR_SHIFT  = 9
);
  logic                                  inclk;
  logic [7:0]                            in;
  logic                                  in_done;
  logic                                  setoff_req;
  logic [7:0]                            setoff_chan;
  logic [8*OFFSET_BYTES+COLOR_SHIFT-1:0] setoff_val;
  logic                                  outclk;
  logic [7:0]                            out;
  logic                                  done;
  logic                                  err;
  logic [1:0]                            err_code;

  modport master (
    output inclk, in, in_done,
    input  setoff_req, setoff_chan, setoff_val, outclk, out, done, err, err_code
  );

  modport slave (
    input  inclk, in, in_done,
    output setoff_req, setoff_chan, setoff_val, outclk, out, done, err, err_code
  );
endinterface

// File: rtl/fgp_rx_parser.sv
// ----------------------------------------------------------------------------
// fgp_rx_parser
// Parses frames of the form
//   [chan (1) | offset (OFFSET_BYTES, MSB first) | pad (PAD_BYTES) |
//    data (DATA_BYTES) | trailing bytes ignored]
// It reports the channel and offset through a one-cycle setoff_req pulse and
// forwards the payload bytes with zero latency on outclk/out.
//
// Optional feature: when the macro FGP_RX_ERR_EN is defined, an illegal channel
// (chan >= CHANNELS) pulses err with code 1 and the rest of the frame is
// dropped. An in_done that arrives before the payload is complete pulses err
// with code 2. Without the macro, err and err_code stay 0 and a short frame
// simply returns the parser to CHAN.
//
// Ports:
//   clk        clock; all logic runs on posedge
//   rst        synchronous, active-high reset
//   bus        fgp_rx_parser_if.slave (byte input and parse results)
//   state_dbg  current FSM state (CHAN=0 OFFSET=1 PAD=2 DATA=3 TAIL=4 DROP=5)
// ----------------------------------------------------------------------------
module fgp_rx_parser #(
  parameter int OFFSET_BYTES = 2,
  parameter int PAD_BYTES    = 125,
  parameter int DATA_BYTES   = 768,
  parameter int CHANNELS     = 2,
  parameter int COLOR_SHIFT  = 9
) (
  input  logic            clk,
  input  logic            rst,
  fgp_rx_parser_if.slave  bus,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    CHAN   = 3'd0,
    OFFSET = 3'd1,
    PAD    = 3'd2,
    DATA   = 3'd3,
    TAIL   = 3'd4,
    DROP   = 3'd5
  } state_t;

  localparam int         OFF_W     = 8 * OFFSET_BYTES;
  localparam int         VAL_W     = OFF_W + COLOR_SHIFT;
  localparam logic [9:0] OFF_LAST  = 10'(OFFSET_BYTES - 1);
  localparam logic [9:0] PAD_LAST  = 10'(PAD_BYTES - 1);
  localparam logic [9:0] DATA_LAST = 10'(DATA_BYTES - 1);

  state_t           state_q;
  state_t           state_nxt;
  logic [9:0]       cnt_q;
  logic [OFF_W-1:0] off_q;
  logic [7:0]       chan_q;

  logic [OFF_W+7:0] off_cat;
  logic [OFF_W-1:0] off_shift;
  logic             bad_chan;
  logic             setoff_req_o;
  logic             outclk_o;
  logic             done_o;

  // The offset value seen by the consumer already contains the byte that is
  // arriving now, so setoff_val is valid in the same cycle as setoff_req.
  assign off_cat   = {off_q, bus.in};
  assign off_shift = off_cat[OFF_W-1:0];

`ifdef FGP_RX_ERR_EN
  assign bad_chan = (state_q == CHAN) && bus.inclk &&
                    ({1'b0, bus.in} >= 9'(CHANNELS));
`else
  assign bad_chan = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CHAN;
      cnt_q   <= '0;
      off_q   <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_nxt;
      // The byte counter restarts at every state change so each field counts
      // from zero.
      if (state_nxt != state_q) begin
        cnt_q <= '0;
      end else if (bus.inclk) begin
        cnt_q <= cnt_q + 10'd1;
      end
      if ((state_q == OFFSET) && bus.inclk) begin
        off_q <= off_shift;
      end
      if ((state_q == CHAN) && bus.inclk) begin
        chan_q <= bus.in;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. The byte in the current cycle is processed first; an
  // in_done in the same cycle then overrides the destination with CHAN.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      CHAN: begin
        if (bus.inclk) begin
          state_nxt = bad_chan ? DROP : OFFSET;
        end
      end
      OFFSET: begin
        if (bus.inclk && (cnt_q == OFF_LAST)) begin
          state_nxt = (PAD_BYTES == 0) ? DATA : PAD;
        end
      end
      PAD: begin
        if (bus.inclk && (cnt_q == PAD_LAST)) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bus.inclk && (cnt_q == DATA_LAST)) begin
          state_nxt = TAIL;
        end
      end
      TAIL:    state_nxt = state_q;
      DROP:    state_nxt = state_q;
      default: state_nxt = CHAN;
    endcase
    if (bus.in_done) begin
      state_nxt = CHAN;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic. Every pulse is held low while rst is asserted, so a byte
  // that arrives in the reset cycle has no effect.
  // --------------------------------------------------------------------------
  always_comb begin
    setoff_req_o = 1'b0;
    outclk_o     = 1'b0;
    done_o       = 1'b0;
    if (!rst) begin
      case (state_q)
        OFFSET: setoff_req_o = bus.inclk && (cnt_q == OFF_LAST);
        DATA: begin
          outclk_o = bus.inclk;
          done_o   = bus.inclk && (cnt_q == DATA_LAST);
        end
        default: begin
          setoff_req_o = 1'b0;
          outclk_o     = 1'b0;
          done_o       = 1'b0;
        end
      endcase
    end
  end

  assign bus.setoff_req  = setoff_req_o;
  assign bus.setoff_chan = chan_q;
  assign bus.setoff_val  = VAL_W'(off_shift) << COLOR_SHIFT;
  assign bus.outclk      = outclk_o;
  assign bus.out         = bus.in;
  assign bus.done        = done_o;
  assign state_dbg       = state_q;

`ifdef FGP_RX_ERR_EN
  logic       short_frame;
  logic       err_o;
  logic [1:0] code_cur;
  logic [1:0] code_q;

  // A frame is short when it ends before the last payload byte has been
  // accepted. An in_done that comes with the last payload byte is a normal
  // end of frame.
  assign short_frame = bus.in_done &&
                       ((state_q == OFFSET) || (state_q == PAD) ||
                        ((state_q == DATA) && !(bus.inclk && (cnt_q == DATA_LAST))));
  assign err_o    = !rst && (bad_chan || short_frame);
  assign code_cur = bad_chan ? 2'd1 : 2'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= 2'd0;
    end else if (err_o) begin
      code_q <= code_cur;
    end
  end

  // The new code is shown in the same cycle as the err pulse, then held.
  assign bus.err      = err_o;
  assign bus.err_code = err_o ? code_cur : code_q;
`else
  assign bus.err      = 1'b0;
  assign bus.err_code = 2'd0;
`endif

endmodule

// File: tb/tb_fgp_rx_parser.sv
module tb_fgp_rx_parser;

  localparam logic [2:0] S_CHAN = 3'd0;
`ifdef FGP_RX_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut_a: default parameters; dut_b: small frame geometry for table tests
  fgp_rx_parser_if #(.OFFSET_BYTES(2), .COLOR_SHIFT(9)) bus_a ();
  fgp_rx_parser_if #(.OFFSET_BYTES(1), .COLOR_SHIFT(9)) bus_b ();
  logic [2:0] state_a;
  logic [2:0] state_b;

  fgp_rx_parser dut_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_a.slave),
    .state_dbg (state_a)
  );

  fgp_rx_parser #(
    .OFFSET_BYTES (1),
    .PAD_BYTES    (0),
    .DATA_BYTES   (3),
    .CHANNELS     (2),
    .COLOR_SHIFT  (9)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_b.slave),
    .state_dbg (state_b)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  logic [7:0]  exp_q[$];
  int          byte_idx, outclk_cnt, done_cnt, req_cnt, err_cnt, done_idx, err_idx;
  logic [24:0] last_val;
  logic [7:0]  last_chan;
  logic [1:0]  last_code;
  logic [7:0]  exp_b;

  task automatic clear_counts();
    byte_idx = 0; outclk_cnt = 0; done_cnt = 0; req_cnt = 0; err_cnt = 0;
    done_idx = -1; err_idx = -1; last_val = '0; last_chan = '0; last_code = '0;
    exp_q.delete();
  endtask

  // Monitor for dut_a, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.inclk) byte_idx++;
      if (bus_a.setoff_req) begin
        req_cnt++;
        last_val  = bus_a.setoff_val;
        last_chan = bus_a.setoff_chan;
      end
      if (bus_a.outclk) begin
        outclk_cnt++;
        if (exp_q.size() == 0) begin
          check("outclk_unexpected", 32'd1, 32'd0);
        end else begin
          exp_b = exp_q.pop_front();
          check("payload", {24'd0, bus_a.out}, {24'd0, exp_b});
        end
      end
      if (bus_a.done) begin
        done_cnt++;
        done_idx = byte_idx;
      end
      if (bus_a.err) begin
        err_cnt++;
        err_idx   = byte_idx;
        last_code = bus_a.err_code;
      end
    end
  end

  // ---------------- driver tasks (dut_a) ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic put_a(input logic [7:0] b, input logic d);
    bus_a.inclk = 1'b1; bus_a.in = b; bus_a.in_done = d;
    @(posedge clk); #1;
    bus_a.inclk = 1'b0; bus_a.in_done = 1'b0;
  endtask

  task automatic send_frame_a(input logic [7:0] chan, input logic [15:0] off,
                              input int ndata, input int ntrail,
                              input bit expect_out, input bit end_done);
    int total;
    int k;
    logic [7:0] b;
    total = 3 + 125 + ndata + ntrail;
    k = 0;
    byte_idx = 0;
    put_a(chan, end_done && (k == total - 1)); k++;
    put_a(off[15:8], end_done && (k == total - 1)); k++;
    put_a(off[7:0], end_done && (k == total - 1)); k++;
    for (int i = 0; i < 125; i++) begin
      b = 8'($urandom_range(0, 255));
      put_a(b, end_done && (k == total - 1)); k++;
    end
    for (int i = 0; i < ndata; i++) begin
      b = 8'($urandom_range(0, 255));
      if (expect_out) exp_q.push_back(b);
      put_a(b, end_done && (k == total - 1)); k++;
    end
    for (int i = 0; i < ntrail; i++) begin
      b = 8'($urandom_range(0, 255));
      put_a(b, end_done && (k == total - 1)); k++;
    end
  endtask

  // ---------------- table vectors (dut_b) ----------------
  typedef struct {
    logic        inclk;
    logic [7:0]  din;
    logic        in_done;
    logic [2:0]  st;
    logic        req;
    logic [16:0] val;
    logic        oclk;
    logic [7:0]  dout;
    logic        dn;
    logic        er;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic i, input logic [7:0] d, input logic id,
                              input logic [2:0] st, input logic rq, input logic [16:0] v,
                              input logic oc, input logic [7:0] o, input logic dn,
                              input logic er, input logic [1:0] cd);
    vec_t r;
    r.inclk = i; r.din = d; r.in_done = id; r.st = st; r.req = rq; r.val = v;
    r.oclk = oc; r.dout = o; r.dn = dn; r.er = er; r.code = cd;
    return r;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bus_a.inclk = 1'b0; bus_a.in = 8'h00; bus_a.in_done = 1'b0;
    bus_b.inclk = 1'b0; bus_b.in = 8'h00; bus_b.in_done = 1'b0;
    clear_counts();

    // frame 00 07 AA BB CC DD(in_done), single-byte frame, short frames, bad chan
    vecs[0]  = mk(1, 8'h00, 0, 3'd0, 0, 17'h0,    0, 8'h00, 0, 0, 2'd0);
    vecs[1]  = mk(1, 8'h07, 0, 3'd1, 1, 17'h0E00, 0, 8'h00, 0, 0, 2'd0);
    vecs[2]  = mk(1, 8'hAA, 0, 3'd3, 0, 17'h0,    1, 8'hAA, 0, 0, 2'd0);
    vecs[3]  = mk(1, 8'hBB, 0, 3'd3, 0, 17'h0,    1, 8'hBB, 0, 0, 2'd0);
    vecs[4]  = mk(1, 8'hCC, 0, 3'd3, 0, 17'h0,    1, 8'hCC, 1, 0, 2'd0);
    vecs[5]  = mk(1, 8'hDD, 1, 3'd4, 0, 17'h0,    0, 8'h00, 0, 0, 2'd0);
    vecs[6]  = mk(0, 8'h00, 0, 3'd0, 0, 17'h0,    0, 8'h00, 0, 0, 2'd0);
    vecs[7]  = mk(1, 8'h01, 1, 3'd0, 0, 17'h0,    0, 8'h00, 0, 0, 2'd0);
    vecs[8]  = mk(0, 8'h00, 0, 3'd0, 0, 17'h0,    0, 8'h00, 0, 0, 2'd0);
    vecs[9]  = mk(1, 8'h00, 0, 3'd0, 0, 17'h0,    0, 8'h00, 0, 0, 2'd0);
    vecs[10] = mk(1, 8'h05, 1, 3'd1, 1, 17'h0A00, 0, 8'h00, 0, ERR_ON, ERR_ON ? 2'd2 : 2'd0);
    vecs[11] = mk(0, 8'h00, 0, 3'd0, 0, 17'h0,    0, 8'h00, 0, 0, ERR_ON ? 2'd2 : 2'd0);
    vecs[12] = mk(1, 8'h03, 0, 3'd0, 0, 17'h0,    0, 8'h00, 0, ERR_ON, ERR_ON ? 2'd1 : 2'd0);
    vecs[13] = mk(1, 8'h09, 0, ERR_ON ? 3'd5 : 3'd1, !ERR_ON, 17'h1200, 0, 8'h00, 0, 0,
                  ERR_ON ? 2'd1 : 2'd0);
    vecs[14] = mk(1, 8'h11, 1, ERR_ON ? 3'd5 : 3'd3, 0, 17'h0, !ERR_ON, 8'h11, 0, 0,
                  ERR_ON ? 2'd1 : 2'd0);
    vecs[15] = mk(0, 8'h00, 0, 3'd0, 0, 17'h0,    0, 8'h00, 0, 0, ERR_ON ? 2'd1 : 2'd0);

    // ---- reset ----
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    #3;
    check("reset_state_a", {29'd0, state_a}, {29'd0, S_CHAN});
    check("reset_state_b", {29'd0, state_b}, {29'd0, S_CHAN});
    check("reset_chan_a", {24'd0, bus_a.setoff_chan}, 32'd0);
    check("reset_code_a", {30'd0, bus_a.err_code}, 32'd0);
    #1;

    // ---- table-driven vectors on dut_b ----
    for (int i = 0; i < 16; i++) begin
      bus_b.inclk = vecs[i].inclk; bus_b.in = vecs[i].din; bus_b.in_done = vecs[i].in_done;
      #4;
      check($sformatf("v%0d_state", i), {29'd0, state_b}, {29'd0, vecs[i].st});
      check($sformatf("v%0d_req", i), {31'd0, bus_b.setoff_req}, {31'd0, vecs[i].req});
      if (vecs[i].req) check($sformatf("v%0d_val", i), {15'd0, bus_b.setoff_val}, {15'd0, vecs[i].val});
      check($sformatf("v%0d_outclk", i), {31'd0, bus_b.outclk}, {31'd0, vecs[i].oclk});
      if (vecs[i].oclk) check($sformatf("v%0d_out", i), {24'd0, bus_b.out}, {24'd0, vecs[i].dout});
      check($sformatf("v%0d_done", i), {31'd0, bus_b.done}, {31'd0, vecs[i].dn});
      check($sformatf("v%0d_err", i), {31'd0, bus_b.err}, {31'd0, vecs[i].er});
      check($sformatf("v%0d_code", i), {30'd0, bus_b.err_code}, {30'd0, vecs[i].code});
      @(posedge clk); #1;
    end
    bus_b.inclk = 1'b0; bus_b.in_done = 1'b0;

    // ---- in_done in idle CHAN is ignored ----
    bus_a.in_done = 1'b1;
    #4;
    check("idle_done_err", {31'd0, bus_a.err}, 32'd0);
    @(posedge clk); #1;
    bus_a.in_done = 1'b0;
    check("idle_done_state", {29'd0, state_a}, {29'd0, S_CHAN});

    // ---- full default frame ----
    clear_counts();
    send_frame_a(8'h01, 16'h0102, 768, 4, 1'b1, 1'b1);
    idle(1);
    check("f1_req_cnt", req_cnt, 1);
    check("f1_setoff_val", {7'd0, last_val}, 32'h0002_0400);
    check("f1_setoff_chan", {24'd0, last_chan}, 32'd1);
    check("f1_outclk_cnt", outclk_cnt, 768);
    check("f1_done_cnt", done_cnt, 1);
    check("f1_done_idx", done_idx, 896);
    check("f1_err_cnt", err_cnt, 0);
    check("f1_state", {29'd0, state_a}, {29'd0, S_CHAN});
    check("f1_chan_held", {24'd0, bus_a.setoff_chan}, 32'd1);

    // ---- back-to-back frames ----
    clear_counts();
    send_frame_a(8'h00, 16'h00FF, 768, 2, 1'b1, 1'b1);
    send_frame_a(8'h01, 16'h1234, 768, 3, 1'b1, 1'b1);
    idle(1);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_req_cnt", req_cnt, 2);
    check("b2b_outclk_cnt", outclk_cnt, 1536);
    check("b2b_last_val", {7'd0, last_val}, 32'h0024_6800);
    check("b2b_queue_empty", exp_q.size(), 0);

    // ---- reset mid-frame, byte in reset cycle ignored ----
    clear_counts();
    send_frame_a(8'h01, 16'h0040, 50, 0, 1'b1, 1'b0);
    rst = 1'b1;
    bus_a.inclk = 1'b1; bus_a.in = 8'h55;
    #4;
    check("rst_cycle_outclk", {31'd0, bus_a.outclk}, 32'd0);
    check("rst_cycle_done", {31'd0, bus_a.done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus_a.inclk = 1'b0;
    check("rst_state", {29'd0, state_a}, {29'd0, S_CHAN});
    clear_counts();
    send_frame_a(8'h01, 16'h0003, 768, 1, 1'b1, 1'b1);
    idle(1);
    check("rst_new_outclk", outclk_cnt, 768);
    check("rst_new_done", done_cnt, 1);
    check("rst_new_val", {7'd0, last_val}, 32'h0000_0600);
    check("rst_new_chan", {24'd0, last_chan}, 32'd1);

`ifdef FGP_RX_ERR_EN
    // ---- bad channel ----
    clear_counts();
    send_frame_a(8'h05, 16'h0102, 768, 2, 1'b0, 1'b1);
    idle(1);
    check("bad_err_cnt", err_cnt, 1);
    check("bad_err_idx", err_idx, 1);
    check("bad_err_code", {30'd0, last_code}, 32'd1);
    check("bad_outclk_cnt", outclk_cnt, 0);
    check("bad_req_cnt", req_cnt, 0);
    check("bad_done_cnt", done_cnt, 0);
    check("bad_state", {29'd0, state_a}, {29'd0, S_CHAN});
    check("bad_code_held", {30'd0, bus_a.err_code}, 32'd1);
    clear_counts();
    send_frame_a(8'h00, 16'h0001, 768, 1, 1'b1, 1'b1);
    idle(1);
    check("recover_done", done_cnt, 1);
    check("recover_outclk", outclk_cnt, 768);
    check("recover_err", err_cnt, 0);

    // ---- short frame ----
    clear_counts();
    send_frame_a(8'h01, 16'h0102, 300, 0, 1'b1, 1'b1);
    idle(1);
    check("short_err_cnt", err_cnt, 1);
    check("short_err_idx", err_idx, 428);
    check("short_code", {30'd0, last_code}, 32'd2);
    check("short_done", done_cnt, 0);
    check("short_state", {29'd0, state_a}, {29'd0, S_CHAN});
    check("short_code_held", {30'd0, bus_a.err_code}, 32'd2);
`else
    // ---- channel not checked ----
    clear_counts();
    send_frame_a(8'h05, 16'h0102, 768, 2, 1'b1, 1'b1);
    idle(1);
    check("nochk_req_cnt", req_cnt, 1);
    check("nochk_chan", {24'd0, last_chan}, 32'd5);
    check("nochk_outclk", outclk_cnt, 768);
    check("nochk_done", done_cnt, 1);
    check("nochk_err", err_cnt, 0);

    // ---- short frame returns silently ----
    clear_counts();
    send_frame_a(8'h01, 16'h0102, 300, 0, 1'b1, 1'b1);
    idle(1);
    check("short_err_cnt", err_cnt, 0);
    check("short_outclk", outclk_cnt, 300);
    check("short_done", done_cnt, 0);
    check("short_state", {29'd0, state_a}, {29'd0, S_CHAN});
    check("short_code", {30'd0, bus_a.err_code}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
